// File: rtl/sisc_pkg.sv
// Shared SISC definitions: memory-arbiter FSM states, requester IDs and default bus widths.
package sisc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_arb_waitcnt.sv
// Wait-state down-counter for mem_arb.
// Latency: load/decrement take effect at the next edge; zero is combinational from the count.
// Backpressure: none; decrements only while en is high and the count is nonzero.
module mem_arb_waitcnt (
    input  logic       clk,
    input  logic       rst_f,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    output logic       zero
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);

endmodule

// File: rtl/mem_arb.sv
// Single-port memory arbiter: one fetch or load/store transaction at a time (MEM_ARB_RR_EN = round-robin, else data-first).
// Latency: gnt/mem_en one cycle after the request is seen in IDLE, done pulse 2+WAIT_CYC cycles after it.
// Backpressure: requesters hold req until done; at least one IDLE cycle separates transactions.
module mem_arb
    import sisc_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int WAIT_CYC = 1
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_gnt,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam bit         HAS_WAIT = (WAIT_CYC > 0);
    localparam logic [3:0] WAIT_LD  = HAS_WAIT ? 4'(WAIT_CYC - 1) : 4'd0;

    arb_state_t    state, state_nxt;
    logic          req_any, win, owner, wc_zero, cap;
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;

    assign req_any = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
    logic last_served;

    // On a tie the requester not served last wins; a lone request always wins.
    always_comb begin
        if (if_req && dm_req) win = ~last_served;
        else                  win = dm_req ? REQ_DM : REQ_IF;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)              last_served <= REQ_DM;
        else if (state == DONE)  last_served <= owner;
    end
`else
    assign win = dm_req ? REQ_DM : REQ_IF;
`endif

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (req_any) state_nxt = ACCESS;
            ACCESS:  state_nxt = HAS_WAIT ? WAIT : DONE;
            WAIT:    if (wc_zero) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = (state == ACCESS);
        mem_we    = (state == ACCESS) && lat_we;
        if_gnt    = (state != IDLE) && (owner == REQ_IF);
        dm_gnt    = (state != IDLE) && (owner == REQ_DM);
        if_done   = (state == DONE) && (owner == REQ_IF);
        dm_done   = (state == DONE) && (owner == REQ_DM);
        mem_addr  = (state != IDLE) ? lat_addr  : '0;
        mem_wdata = (state != IDLE) ? lat_wdata : '0;
    end

    // Winner's request is frozen here so later input changes cannot disturb the access.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            owner     <= REQ_IF;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if ((state == IDLE) && req_any) begin
            owner     <= win;
            lat_we    <= (win == REQ_DM) && dm_we;
            lat_addr  <= (win == REQ_DM) ? dm_addr  : if_addr;
            lat_wdata <= (win == REQ_DM) ? dm_wdata : '0;
        end
    end

    mem_arb_waitcnt u_waitcnt (
        .clk      (clk),
        .rst_f    (rst_f),
        .load     (state == ACCESS),
        .load_val (WAIT_LD),
        .en       (state == WAIT),
        .zero     (wc_zero)
    );

    assign cap = ((state == ACCESS) && !HAS_WAIT) || ((state == WAIT) && wc_zero);

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if (cap) begin
            if (owner == REQ_IF)     if_rdata <= mem_rdata;
            else if (!lat_we)        dm_rdata <= mem_rdata;
        end
    end

endmodule
